// File: rtl/lh_multi_req_sched.sv
// rtl/lh_multi_req_sched.sv - round-robin scheduler sharing one light_hash core among N_REQ byte streams
// Optional watchdog on core wait states: define LH_SCHED_TIMEOUT_EN.
module lh_multi_req_sched #(
    parameter int N_REQ       = 4,
    parameter int ID_W        = $clog2(N_REQ),
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_byte,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         core_byte,
    output logic               core_valid,
    input  logic               core_busy,
    input  logic [63:0]        core_digest,
    input  logic               core_dig_rdy,
    input  logic               core_err,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [63:0]        rsp_digest,
    output logic [ID_W-1:0]    rsp_id,
    output logic [1:0]         rsp_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_WSTART, S_ACCEPT, S_SEND,
        S_WBYTE, S_END, S_WDIG, S_DRAIN, S_RSP
    } state_t;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_BYTE  = 2'b01;
    localparam logic [1:0] ERR_CORE  = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    if (N_REQ < 2 || N_REQ > 16 || ID_W != $clog2(N_REQ) || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("lh_multi_req_sched: unsupported parameter set");
    end

    state_t            r_state;
    state_t            w_next;
    logic [ID_W-1:0]   r_grant;
    logic [ID_W-1:0]   r_rr;
    logic [7:0]        r_byte;
    logic              r_last;
    logic              r_last_seen;
    logic [1:0]        r_err;
    logic [63:0]       r_digest;

    logic [N_REQ-1:0]  w_onehot;
    logic              w_sel_valid;
    logic [7:0]        w_sel_byte;
    logic              w_sel_last;
    logic              w_sel_bad;
    logic [ID_W-1:0]   w_pick;
    logic              w_tmo;

    // First requesting index at or after the rr pointer, wrapping around.
    function automatic logic [ID_W-1:0] f_pick(input logic [N_REQ-1:0] valid,
                                               input logic [ID_W-1:0]  rr);
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = rr;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr) + k) % N_REQ;
            if (!found && valid[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
        return pick;
    endfunction

    assign w_pick      = f_pick(req_valid, r_rr);
    assign w_onehot    = {{(N_REQ-1){1'b0}}, 1'b1} << r_grant;
    assign w_sel_valid = req_valid[r_grant];
    assign w_sel_byte  = req_byte[8*r_grant +: 8];
    assign w_sel_last  = req_last[r_grant];
    assign w_sel_bad   = (w_sel_byte == 8'h00) || (w_sel_byte == 8'hFF);

`ifdef LH_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_tmo_cnt;
    logic          w_in_wait;

    assign w_in_wait = (r_state == S_WSTART) || (r_state == S_WBYTE) || (r_state == S_WDIG);
    assign w_tmo     = w_in_wait && (r_tmo_cnt >= TW'(TIMEOUT_CYC - 1));

    // Leaving a wait state always passes through a non-wait state, so the count restarts on entry.
    always_ff @(posedge clk) begin
        if (rst || !w_in_wait) begin
            r_tmo_cnt <= '0;
        end else if (!w_tmo) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        req_ready  = '0;
        core_valid = 1'b0;
        core_byte  = 8'h00;
        case (r_state)
            S_IDLE:   if (|req_valid) w_next = S_START;
            S_START: begin
                core_byte  = 8'hFF;
                core_valid = 1'b1;
                w_next     = S_WSTART;
            end
            S_WSTART: begin
                if (!core_busy) w_next = S_ACCEPT;
                else if (w_tmo) w_next = S_DRAIN;
            end
            S_ACCEPT: begin
                req_ready = w_onehot;
                if (w_sel_valid) w_next = w_sel_bad ? S_END : S_SEND;
            end
            S_SEND: begin
                core_byte  = r_byte;
                core_valid = 1'b1;
                w_next     = S_WBYTE;
            end
            S_WBYTE: begin
                if (core_err)        w_next = r_last_seen ? S_RSP : S_DRAIN;
                else if (!core_busy) w_next = r_last ? S_END : S_ACCEPT;
                else if (w_tmo)      w_next = r_last_seen ? S_RSP : S_DRAIN;
            end
            S_END: begin
                core_byte  = 8'h00;
                core_valid = 1'b1;
                w_next     = S_WDIG;
            end
            S_WDIG: begin
                if (core_dig_rdy || w_tmo) w_next = r_last_seen ? S_RSP : S_DRAIN;
            end
            S_DRAIN: begin
                req_ready = w_onehot;
                if (w_sel_valid && w_sel_last) w_next = S_RSP;
            end
            S_RSP:    if (rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_rr        <= '0;
            r_byte      <= 8'h00;
            r_last      <= 1'b0;
            r_last_seen <= 1'b0;
            r_err       <= ERR_OK;
            r_digest    <= 64'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (|req_valid) begin
                    r_grant     <= w_pick;
                    r_last_seen <= 1'b0;
                    r_last      <= 1'b0;
                    r_err       <= ERR_OK;
                    r_digest    <= 64'd0;
                end
                S_WSTART: if (core_busy && w_tmo) r_err <= ERR_TMO;
                S_ACCEPT: if (w_sel_valid) begin
                    r_byte <= w_sel_byte;
                    r_last <= w_sel_last;
                    if (w_sel_last) r_last_seen <= 1'b1;
                    if (w_sel_bad)  r_err <= ERR_BYTE;
                end
                S_WBYTE: begin
                    if (core_err)                r_err <= ERR_CORE;
                    else if (core_busy && w_tmo) r_err <= ERR_TMO;
                end
                // A digest is only meaningful when the message reached the core cleanly.
                S_WDIG: begin
                    if (core_dig_rdy) begin
                        if (r_err == ERR_OK) r_digest <= core_digest;
                    end else if (w_tmo && r_err == ERR_OK) begin
                        r_err <= ERR_TMO;
                    end
                end
                S_RSP: if (rsp_ready) begin
                    r_rr <= (r_grant == ID_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid  = (r_state == S_RSP);
    assign rsp_digest = rsp_valid ? r_digest : 64'd0;
    assign rsp_id     = rsp_valid ? r_grant  : '0;
    assign rsp_err    = rsp_valid ? r_err    : ERR_OK;

endmodule

// File: tb/tb_lh_multi_req_sched.sv
// tb/tb_lh_multi_req_sched.sv - self-checking bench for lh_multi_req_sched with a behavioural light_hash stand-in
module tb_lh_multi_req_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_byte = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic [7:0]  core_byte;
    logic        core_valid;
    logic        core_busy;
    logic [63:0] core_digest;
    logic        core_dig_rdy;
    logic        core_err;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_digest;
    logic [1:0]  rsp_id;
    logic [1:0]  rsp_err;

    int checks = 0;
    int errors = 0;

    lh_multi_req_sched #(.N_REQ(4), .ID_W(2), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_byte(req_byte), .req_last(req_last), .req_ready(req_ready),
        .core_byte(core_byte), .core_valid(core_valid), .core_busy(core_busy),
        .core_digest(core_digest), .core_dig_rdy(core_dig_rdy), .core_err(core_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_digest(rsp_digest),
        .rsp_id(rsp_id), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] DIG_INIT = 64'h0123_4567_89AB_CDEF;

    function automatic logic [63:0] dig_step(input logic [63:0] d, input logic [7:0] b);
        return {d[58:0], d[63:59]} ^ {8'd0, b, 48'd0} ^ {56'd0, b};
    endfunction

    function automatic logic [63:0] dig_f(input logic [31:0] data, input int len);
        logic [63:0] d;
        d = DIG_INIT;
        for (int i = 0; i < len; i++) d = dig_step(d, data[8*i +: 8]);
        return d;
    endfunction

    // Core stand-in: busy for 2 cycles per pulse, digest ready after the 00 marker settles.
    int          busy_cnt;
    logic        stuck = 1'b0;
    logic        err_inj = 1'b0;
    logic        abort = 1'b0;
    logic        pend_dig;
    logic [63:0] mdig;
    logic [7:0]  core_log[$];

    always @(posedge clk) begin
        if (rst) begin
            busy_cnt <= 0;
            pend_dig <= 1'b0;
            mdig     <= 64'd0;
        end else begin
            if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
            if (core_valid) begin
                core_log.push_back(core_byte);
                busy_cnt <= 2;
                if (core_byte == 8'hFF) begin
                    mdig     <= DIG_INIT;
                    pend_dig <= 1'b0;
                end else if (core_byte == 8'h00) begin
                    pend_dig <= 1'b1;
                end else begin
                    mdig <= dig_step(mdig, core_byte);
                end
            end
        end
    end

    assign core_busy    = (busy_cnt != 0) || stuck;
    assign core_dig_rdy = pend_dig && (busy_cnt == 0);
    assign core_err     = err_inj && (busy_cnt != 0);
    assign core_digest  = mdig;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_msg(input int rid, input logic [31:0] data, input int len);
        int   cyc;
        logic done;
        logic quit;
        quit = 1'b0;
        for (int i = 0; i < len && !quit; i++) begin
            req_valid[rid]        = 1'b1;
            req_byte[8*rid +: 8]  = data[8*i +: 8];
            req_last[rid]         = (i == len - 1);
            cyc  = 0;
            done = 1'b0;
            while (!done && !quit) begin
                @(negedge clk);
                if (abort) begin
                    quit = 1'b1;
                end else if (req_ready[rid]) begin
                    @(posedge clk);
                    #1;
                    done = 1'b1;
                end else begin
                    cyc++;
                    if (cyc > 600) begin
                        checks++;
                        errors++;
                        $display("FAIL send_timeout rid=%0d byte=%0d: req_ready never came", rid, i);
                        quit = 1'b1;
                    end
                end
            end
        end
        req_valid[rid] = 1'b0;
        req_last[rid]  = 1'b0;
    endtask

    task automatic get_rsp(input logic [1:0] eid, input logic [1:0] eerr,
                           input logic [63:0] edig, input int hold);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (!rsp_valid && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        if (!rsp_valid) begin
            chk("rsp_timeout", {79'd0, rsp_valid}, 80'd1);
            return;
        end
        for (int h = 0; h < hold; h++) begin
            chk("rsp_hold", {6'd0, rsp_valid, rsp_id, rsp_err, req_ready, core_valid, rsp_digest},
                {6'd0, 1'b1, eid, eerr, 4'b0000, 1'b0, edig});
            @(negedge clk);
        end
        chk("rsp_id", {78'd0, rsp_id}, {78'd0, eid});
        chk("rsp_err", {78'd0, rsp_err}, {78'd0, eerr});
        chk("rsp_digest", {16'd0, rsp_digest}, {16'd0, edig});
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic wait_log(input int n);
        int cyc;
        cyc = 0;
        while (core_log.size() < n && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        chk("wait_core_log", {79'd0, core_log.size() >= n}, 80'd1);
    endtask

    typedef struct {
        int          rid;
        logic [31:0] data;
        int          len;
        logic        inj;
        int          hold;
        logic [1:0]  exp_err;
        logic [47:0] exp_seq;
        int          seq_len;
    } vec_t;

    vec_t        vt[7];
    logic [47:0] act_seq;

    initial begin
        vt[0] = '{0, 32'h0063_6261, 3, 1'b0, 0, 2'b00, 48'h0000_6362_61FF, 5};
        vt[1] = '{1, 32'h0042_FF41, 3, 1'b0, 0, 2'b01, 48'h0000_0000_41FF, 3};
        vt[2] = '{3, 32'h0000_005A, 1, 1'b0, 6, 2'b00, 48'h0000_0000_5AFF, 3};
        vt[3] = '{2, 32'h0000_7700, 2, 1'b0, 0, 2'b01, 48'h0000_0000_00FF, 2};
        vt[4] = '{1, 32'h4030_2010, 4, 1'b0, 0, 2'b00, 48'h0040_3020_10FF, 6};
        vt[5] = '{2, 32'h0000_2211, 2, 1'b1, 0, 2'b10, 48'h0000_0000_11FF, 2};
        vt[6] = '{0, 32'h0000_FF55, 2, 1'b0, 0, 2'b01, 48'h0000_0000_55FF, 3};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {54'd0, req_ready, core_valid, core_byte, rsp_valid, rsp_id, rsp_err, 6'd0},
            80'd0);
        chk("reset_digest", {16'd0, rsp_digest}, 80'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Tie on 0 and 2 from rr=0, then from rr=3 (wraps to 0).
        for (int t = 0; t < 2; t++) begin
            fork
                send_msg(0, 32'h01, 1);
                send_msg(2, 32'h02, 1);
            join_none
            get_rsp(2'd0, 2'b00, dig_f(32'h01, 1), 0);
            get_rsp(2'd2, 2'b00, dig_f(32'h02, 1), 0);
        end
        send_msg(1, 32'h33, 1);
        get_rsp(2'd1, 2'b00, dig_f(32'h33, 1), 0);
        // rr=2 now: requester 2 wins the tie.
        fork
            send_msg(0, 32'h04, 1);
            send_msg(2, 32'h05, 1);
        join_none
        get_rsp(2'd2, 2'b00, dig_f(32'h05, 1), 0);
        get_rsp(2'd0, 2'b00, dig_f(32'h04, 1), 0);

        for (int v = 0; v < 7; v++) begin
            core_log.delete();
            err_inj = vt[v].inj;
            send_msg(vt[v].rid, vt[v].data, vt[v].len);
            get_rsp(2'(vt[v].rid), vt[v].exp_err,
                    (vt[v].exp_err == 2'b00) ? dig_f(vt[v].data, vt[v].len) : 64'd0, vt[v].hold);
            err_inj = 1'b0;
            act_seq = '0;
            for (int i = 0; i < core_log.size() && i < 6; i++) act_seq[8*i +: 8] = core_log[i];
            chk($sformatf("core_count_v%0d", v), 80'(core_log.size()), 80'(vt[v].seq_len));
            chk($sformatf("core_seq_v%0d", v), {32'd0, act_seq}, {32'd0, vt[v].exp_seq});
        end

        // Core busy stuck after the first payload byte.
        core_log.delete();
        fork
            send_msg(0, 32'h0000_3231, 2);
        join_none
        wait_log(2);
        stuck = 1'b1;
`ifdef LH_SCHED_TIMEOUT_EN
        get_rsp(2'd0, 2'b11, 64'd0, 0);
        stuck = 1'b0;
        chk("tmo_core_count", 80'(core_log.size()), 80'd2);
`else
        repeat (30) @(negedge clk);
        chk("stuck_wait", {74'd0, rsp_valid, req_ready, core_valid}, 80'd0);
        chk("stuck_core_count", 80'(core_log.size()), 80'd2);
        stuck = 1'b0;
        get_rsp(2'd0, 2'b00, dig_f(32'h0000_3231, 2), 0);
`endif

        // Leave rr at 3 so a stale pointer after reset would favour requester 3.
        send_msg(2, 32'h66, 1);
        get_rsp(2'd2, 2'b00, dig_f(32'h66, 1), 0);

        core_log.delete();
        fork
            send_msg(0, 32'h4443_4241, 4);
        join_none
        wait_log(3);
        rst   = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_outputs", {54'd0, req_ready, core_valid, core_byte, rsp_valid, rsp_id, rsp_err, 6'd0},
            80'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        @(posedge clk);
        #1;
        fork
            send_msg(2, 32'h21, 1);
            send_msg(3, 32'h5A, 1);
        join_none
        get_rsp(2'd2, 2'b00, dig_f(32'h21, 1), 0);
        get_rsp(2'd3, 2'b00, dig_f(32'h5A, 1), 0);

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
